phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Parametrised successor to the fixed 3-phase clock generator that drives the ctrl/read/write phases of the Blizzard 4 core.
- Generates PHASES one-hot phase enables plus end-of-phase strobes from a single clk. Per-phase wait states and a ready handshake can stretch each phase.
- Adds run/halt/single-step control and a machine-cycle counter for debug.
- Sits at top level in place of the clock generator; bus modules qualify their actions with phase_strb.

Parameters:
- PHASES, 3, number of phases per machine cycle (>=2).
- WAIT_W, 4, width of each per-phase static wait-state count.
- CYCLE_W, 32, width of the machine-cycle counter.
- AUTO_RUN, 1, 1 = enter RUN after reset; 0 = enter HALTED.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = free-run, 0 = stop at the next cycle boundary.
- step  in  1  single-cycle pulse request, sampled only in HALTED.
- ready  in  1  phase-extension handshake; sampled on the last tick of each phase.
- wait_cycles  in  PHASES*WAIT_W  extra ticks per phase; slice p belongs to phase p. Sampled on entry to each phase.
- phase_en  out  PHASES  one-hot; high for the whole duration of the active phase.
- phase_strb  out  PHASES  one-hot single-tick pulse on the committing tick of the active phase.
- phase_idx  out  $clog2(PHASES)  index of the current phase.
- cycle_end  out  1  pulse coincident with phase_strb[PHASES-1].
- running  out  1  state is RUN, STEP or DRAIN.
- halted  out  1  state is HALTED.
- cycle_count  out  CYCLE_W  completed machine cycles; wraps modulo 2^CYCLE_W.

Behaviour:
- Reset (async, reset=0):
  - state = RUN if AUTO_RUN, else HALTED.
  - phase_idx = 0, wait counter = 0, cycle_count = 0.
  - phase_en, phase_strb and cycle_end all 0.
  - With AUTO_RUN, phase_en[0] rises on the first clk edge after reset deasserts.
- Phase timing:
  - Phase p lasts 1 + wait_cycles[p] ticks, plus one extra tick for every final tick on which ready=0.
  - ready is ignored while the wait counter is nonzero.
  - Commit tick = wait counter 0 and ready=1. On it, phase_strb[p]=1 and the next tick enters (p+1) mod PHASES.
  - Minimum phase length is 1 tick; with all waits 0 and ready=1, one machine cycle = PHASES ticks.
- States:
  - HALTED:
    - phase_en = 0, phase_idx = 0.
    - run=1 -> RUN; phase_en[0] is asserted on the next edge.
    - step=1 (with run=0) -> STEP.
    - run has priority when run and step are both high.
  - RUN:
    - Phases sequence continuously.
    - run=0 sampled on any tick -> DRAIN.
  - DRAIN:
    - Finishes the current cycle. On cycle_end -> HALTED.
    - run=1 again before cycle_end -> back to RUN, with no gap.
  - STEP:
    - Runs exactly one full cycle from phase 0. On cycle_end -> HALTED.
    - step is ignored here. run=1 converts the state to RUN.
- Halt is only ever taken at a cycle boundary; a partial cycle is never abandoned except by reset.
- cycle_count increments on the tick that cycle_end is high and wraps from all-ones to 0.
- Outputs are registered: phase_en, phase_strb, cycle_end and phase_idx all change only on clk edges.
- Reset mid-phase clears state immediately; the interrupted cycle is not counted.
- Invariants:
  - phase_strb implies phase_en on the same bit.
  - At most one phase_en bit is high.
  - running and halted are mutually exclusive, and exactly one of them is high.

Decomposition:
- Shared types package holds:
  - state encoding (HALTED, RUN, DRAIN, STEP);
  - the PHASES default of 3;
  - the phase-index width function.
- One sub-module, phase_timer: loads wait_cycles[p] on phase entry, counts down, qualifies with ready, and emits the commit tick.
- State machine, phase ring and cycle counter live in the top of the block.

Test Plan:
- Reset, AUTO_RUN=1, waits 0, ready=1 -> phase_en sequence 001, 010, 100, 001; cycle_end every 3rd tick; cycle_count=4 after 12 ticks.
- wait_cycles phase1=2, others 0 -> phase_en[1] high for 3 ticks; cycle length 5; single phase_strb[1] on the third tick.
- ready=0 held 4 ticks on phase 2's final tick -> phase 2 extended by 4 ticks; phase_strb[2] and cycle_end only after ready returns to 1.
- run dropped during phase 1 -> phases 1 and 2 complete, cycle_end fires, halted=1, phase_en=0; then a 1-tick step pulse -> exactly 3 ticks of phases, cycle_count+1, halted again.
- run and step both high in HALTED -> RUN, free-running, not halting after one cycle.
- Async reset asserted mid-phase 2 with cycle_count=7 -> outputs clear immediately; cycle_count=0; restart at phase 0 after release.
- CYCLE_W=4, 16 cycles from reset -> cycle_count wraps 15 to 0.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared types and helpers for the phase sequencer and its phase timer.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HALTED,
        ST_RUN,
        ST_DRAIN,
        ST_STEP
    } seq_state_e;

    localparam int unsigned PHASES_DEFAULT = 3;

    // Width of a phase index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_sequencer_timer.sv
// Per-phase wait-state counter: loads the wait count on phase entry, counts it
// down, and flags the upcoming tick as committing once it is zero and ready is high.
module phase_timer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              enter,
    input  logic [WAIT_W-1:0] wait_val,
    input  logic              ready,
    output logic              commit_d
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Values describe the tick about to start, so the sequencer can register
    // its strobe alongside the phase enable. ready only matters once cnt_d is 0.
    always_comb begin
        cnt_d = '0;
        if (active) begin
            if (enter) begin
                cnt_d = wait_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - WAIT_W'(1);
            end
        end
        commit_d = active && (cnt_d == '0) && ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: one-hot phase enables and commit strobes with wait states,
// ready stretching, run/halt/single-step control and a machine-cycle counter.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned PHASES   = PHASES_DEFAULT,
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned CYCLE_W  = 32,
    parameter bit          AUTO_RUN = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          step,
    input  logic                          ready,
    input  logic [PHASES*WAIT_W-1:0]      wait_cycles,
    output logic [PHASES-1:0]             phase_en,
    output logic [PHASES-1:0]             phase_strb,
    output logic [idx_width(PHASES)-1:0]  phase_idx,
    output logic                          cycle_end,
    output logic                          running,
    output logic                          halted,
    output logic [CYCLE_W-1:0]            cycle_count
);

    localparam int unsigned      IDX_W       = idx_width(PHASES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PHASES - 1);
    localparam seq_state_e       RESET_STATE = AUTO_RUN ? ST_RUN : ST_HALTED;

    seq_state_e         state_q, state_d;
    logic               active_q;
    logic [IDX_W-1:0]   phase_idx_q, phase_idx_d;
    logic [PHASES-1:0]  phase_en_q, phase_en_d;
    logic [PHASES-1:0]  phase_strb_q, phase_strb_d;
    logic               cycle_end_q, cycle_end_d;
    logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;

    logic               go;
    logic               boundary;
    logic               enter;
    logic               commit_d;
    logic [WAIT_W-1:0]  wait_sel;

    // Control decisions are made at each edge for the tick that follows it;
    // a halt is only taken when the tick just finished closed a machine cycle.
    always_comb begin
        state_d  = state_q;
        go       = 1'b0;
        boundary = !active_q || cycle_end_q;
        case (state_q)
            ST_HALTED: begin
                if (run) begin
                    state_d = ST_RUN;
                    go      = 1'b1;
                end else if (step) begin
                    state_d = ST_STEP;
                    go      = 1'b1;
                end
            end
            ST_RUN: begin
                if (run) begin
                    go = 1'b1;
                end else if (boundary) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                    go      = 1'b1;
                end
            end
            ST_DRAIN, ST_STEP: begin
                if (run) begin
                    state_d = ST_RUN;
                    go      = 1'b1;
                end else if (boundary) begin
                    state_d = ST_HALTED;
                end else begin
                    go = 1'b1;
                end
            end
            default: state_d = ST_HALTED;
        endcase

        enter       = 1'b0;
        phase_idx_d = '0;
        if (go) begin
            if (!active_q) begin
                enter = 1'b1;
            end else if (|phase_strb_q) begin
                enter       = 1'b1;
                phase_idx_d = (phase_idx_q == LAST_IDX) ? '0 : phase_idx_q + IDX_W'(1);
            end else begin
                phase_idx_d = phase_idx_q;
            end
        end

        wait_sel      = wait_cycles[phase_idx_d*WAIT_W +: WAIT_W];
        phase_en_d    = go ? (PHASES'(1) << phase_idx_d) : '0;
        cycle_count_d = cycle_count_q + CYCLE_W'(cycle_end_q);
    end

    always_comb begin
        phase_strb_d = commit_d ? phase_en_d : '0;
        cycle_end_d  = phase_strb_d[PHASES-1];
    end

    phase_timer #(
        .WAIT_W(WAIT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .active   (go),
        .enter    (enter),
        .wait_val (wait_sel),
        .ready    (ready),
        .commit_d (commit_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RESET_STATE;
            active_q      <= 1'b0;
            phase_idx_q   <= '0;
            phase_en_q    <= '0;
            phase_strb_q  <= '0;
            cycle_end_q   <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= go;
            phase_idx_q   <= phase_idx_d;
            phase_en_q    <= phase_en_d;
            phase_strb_q  <= phase_strb_d;
            cycle_end_q   <= cycle_end_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign phase_en    = phase_en_q;
    assign phase_strb  = phase_strb_q;
    assign phase_idx   = phase_idx_q;
    assign cycle_end   = cycle_end_q;
    assign cycle_count = cycle_count_q;
    assign halted      = (state_q == ST_HALTED);
    assign running     = (state_q != ST_HALTED);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed scoreboard bench for phase_sequencer (3 phases) with a 4-bit-counter twin.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b1;
    logic        step = 1'b0;
    logic        ready = 1'b1;
    logic [11:0] wait_cycles = '0;

    logic [2:0]  phase_en, phase_strb, phase_en4, phase_strb4;
    logic [1:0]  phase_idx, phase_idx4;
    logic        cycle_end, running, halted, cycle_end4, running4, halted4;
    logic [31:0] cycle_count;
    logic [3:0]  cycle_count4;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned model_cnt = 0;

    typedef struct {
        string       tag;
        logic [2:0]  en;
        logic [2:0]  strb;
        logic        hlt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    phase_sequencer #(
        .PHASES(3), .WAIT_W(4), .CYCLE_W(32), .AUTO_RUN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .ready(ready),
        .wait_cycles(wait_cycles), .phase_en(phase_en), .phase_strb(phase_strb),
        .phase_idx(phase_idx), .cycle_end(cycle_end), .running(running),
        .halted(halted), .cycle_count(cycle_count)
    );

    phase_sequencer #(
        .PHASES(3), .WAIT_W(4), .CYCLE_W(4), .AUTO_RUN(1'b1)
    ) dut4 (
        .clk(clk), .reset(reset), .run(run), .step(step), .ready(ready),
        .wait_cycles(wait_cycles), .phase_en(phase_en4), .phase_strb(phase_strb4),
        .phase_idx(phase_idx4), .cycle_end(cycle_end4), .running(running4),
        .halted(halted4), .cycle_count(cycle_count4)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s.%s got %0h exp %0h", tag, fld, got, want);
        end
    endtask

    // Expected outputs for one tick; the cycle counter seen during a tick
    // equals the number of cycle_end ticks before it.
    task automatic push(input string tag, input logic [2:0] en, input logic [2:0] strb,
                        input logic hlt);
        exp_t e;
        e.tag  = tag;
        e.en   = en;
        e.strb = strb;
        e.hlt  = hlt;
        e.cnt  = model_cnt;
        sb.push_back(e);
        if (strb[2]) model_cnt++;
    endtask

    task automatic push_cycle(input string tag);
        push(tag, 3'b001, 3'b001, 1'b0);
        push(tag, 3'b010, 3'b010, 1'b0);
        push(tag, 3'b100, 3'b100, 1'b0);
    endtask

    task automatic check_front();
        exp_t       e;
        logic [1:0] idx_exp;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty got 0 entries exp >=1");
            return;
        end
        e = sb.pop_front();
        idx_exp = e.en[2] ? 2'd2 : (e.en[1] ? 2'd1 : 2'd0);
        chk(e.tag, "phase_en",     32'(phase_en),     32'(e.en));
        chk(e.tag, "phase_strb",   32'(phase_strb),   32'(e.strb));
        chk(e.tag, "cycle_end",    32'(cycle_end),    32'(e.strb[2]));
        chk(e.tag, "phase_idx",    32'(phase_idx),    32'(idx_exp));
        chk(e.tag, "halted",       32'(halted),       32'(e.hlt));
        chk(e.tag, "running",      32'(running),      32'(!e.hlt));
        chk(e.tag, "cycle_count",  cycle_count,       e.cnt);
        chk(e.tag, "cycle_count4", 32'(cycle_count4), 32'(e.cnt[3:0]));
    endtask

    task automatic run_ticks();
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            check_front();
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values with AUTO_RUN: running, nothing enabled.
        push("reset", 3'b000, 3'b000, 1'b0);
        run_ticks();
        reset = 1'b1;

        // Free run, zero waits: four full cycles then the start of the fifth.
        for (int i = 0; i < 4; i++) push_cycle("freerun");
        push("freerun", 3'b001, 3'b001, 1'b0);
        run_ticks();

        // Two wait states on phase 1.
        wait_cycles = 12'h020;
        push("wait1", 3'b010, 3'b000, 1'b0);
        push("wait1", 3'b010, 3'b000, 1'b0);
        push("wait1", 3'b010, 3'b010, 1'b0);
        push("wait1", 3'b100, 3'b100, 1'b0);
        push("wait1", 3'b001, 3'b001, 1'b0);
        run_ticks();
        // ready low while the wait counter is still nonzero has no effect.
        ready = 1'b0;
        push("wait1_rdy", 3'b010, 3'b000, 1'b0);
        run_ticks();
        push("wait1_rdy", 3'b010, 3'b000, 1'b0);
        run_ticks();
        ready = 1'b1;
        push("wait1_rdy", 3'b010, 3'b010, 1'b0);
        push("wait1_rdy", 3'b100, 3'b100, 1'b0);
        run_ticks();
        wait_cycles = '0;

        // ready held low for four ticks stretches phase 2 by four ticks.
        push("ready", 3'b001, 3'b001, 1'b0);
        push("ready", 3'b010, 3'b010, 1'b0);
        run_ticks();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) push("ready_lo", 3'b100, 3'b000, 1'b0);
        run_ticks();
        ready = 1'b1;
        push("ready_hi", 3'b100, 3'b100, 1'b0);
        run_ticks();

        // run dropped in phase 1: the cycle drains, then halts.
        push("drain", 3'b001, 3'b001, 1'b0);
        push("drain", 3'b010, 3'b010, 1'b0);
        run_ticks();
        run = 1'b0;
        push("drain", 3'b100, 3'b100, 1'b0);
        push("halt", 3'b000, 3'b000, 1'b1);
        push("halt", 3'b000, 3'b000, 1'b1);
        run_ticks();

        // Single step: exactly one cycle, then halted again.
        step = 1'b1;
        push("step", 3'b001, 3'b001, 1'b0);
        run_ticks();
        step = 1'b0;
        push("step", 3'b010, 3'b010, 1'b0);
        push("step", 3'b100, 3'b100, 1'b0);
        push("step_halt", 3'b000, 3'b000, 1'b1);
        push("step_halt", 3'b000, 3'b000, 1'b1);
        run_ticks();

        // run and step together: run wins and keeps free-running.
        run  = 1'b1;
        step = 1'b1;
        push("run_step", 3'b001, 3'b001, 1'b0);
        run_ticks();
        step = 1'b0;
        push("run_step", 3'b010, 3'b010, 1'b0);
        push("run_step", 3'b100, 3'b100, 1'b0);
        push_cycle("run_step");
        run_ticks();

        // Fresh reset, seven cycles with a 4-tick phase 2, then reset mid-phase 2.
        reset = 1'b0;
        model_cnt = 0;
        push("rst_a", 3'b000, 3'b000, 1'b0);
        #1 check_front();
        @(negedge clk);
        wait_cycles = 12'h300;
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push("seven", 3'b001, 3'b001, 1'b0);
            push("seven", 3'b010, 3'b010, 1'b0);
            for (int k = 0; k < 3; k++) push("seven", 3'b100, 3'b000, 1'b0);
            push("seven", 3'b100, 3'b100, 1'b0);
        end
        push("mid", 3'b001, 3'b001, 1'b0);
        push("mid", 3'b010, 3'b010, 1'b0);
        push("mid", 3'b100, 3'b000, 1'b0);
        run_ticks();
        reset = 1'b0;
        model_cnt = 0;
        push("rst_mid", 3'b000, 3'b000, 1'b0);
        #1 check_front();
        @(negedge clk);
        wait_cycles = '0;
        reset = 1'b1;

        // Restart at phase 0; 17 cycles take the 4-bit counter through 15 -> 0.
        for (int i = 0; i < 17; i++) push_cycle("wrap");
        push("wrap", 3'b001, 3'b001, 1'b0);
        run_ticks();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
